mem_arbiter: RTL and testbench

- Shares the single-port byte memory between two requesters: port A (UART command controller) and port B (a second on-chip master, e.g. a CPU or debug engine).
- Performs round-robin or fixed-priority arbitration and drives the memory's read/write strobes, address and write data.
- Returns read data to the winning port with a fixed latency.
- Blocks out-of-range accesses before they reach the memory.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_rr_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port byte-memory arbiter.
// The round-robin picker and any future two-master arbiters reuse these.
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        PortA = 1'b0,
        PortB = 1'b1
    } port_id_e;

    // Also used as the size of the byte memory behind the arbiter.
    localparam int unsigned DefaultAddrLimit = 32'h2000;

    localparam logic CommandRead  = 1'b0;
    localparam logic CommandWrite = 1'b1;

    // One access as registered at the end of the IDLE cycle that granted it.
    typedef struct packed {
        logic        we;
        logic        in_range;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } access_t;

    // Full 16-bit compare: no wrap-around or truncation of the address.
    function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned limit);
        return {16'h0000, addr} < limit;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational winner select between two requesters, round-robin or fixed priority.
// Port A wins every contention when FIXED_PRIORITY is non-zero.
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic     a_req,
    input  logic     b_req,
    input  port_id_e last_grant,
    output logic     valid,
    output port_id_e winner
);

    always_comb begin
        valid  = a_req | b_req;
        winner = PortA;
        if (a_req && b_req) begin
            // Round-robin: whoever was not served last goes first.
            if (FIXED_PRIORITY == 0 && last_grant == PortA) begin
                winner = PortB;
            end
        end else if (b_req) begin
            winner = PortB;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port byte memory: one access per two cycles,
// out-of-range accesses are blocked and flagged, reads return with fixed latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT     = DefaultAddrLimit,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,
    output logic        b_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_write_byte,
    input  logic [7:0]  mem_read_byte
);

    arb_state_e state_q, state_d;
    port_id_e   last_grant_q;
    port_id_e   port_q;
    port_id_e   pick_winner;
    logic       pick_valid;
    access_t    acc_q, acc_sel;
    logic       sample;
    logic       rd_done;
    logic [7:0] cap_byte;
    logic       a_rvalid_q, b_rvalid_q;
    logic [7:0] a_rdata_q, b_rdata_q;

    rr_pick2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .a_req     (a_req),
        .b_req     (b_req),
        .last_grant(last_grant_q),
        .valid     (pick_valid),
        .winner    (pick_winner)
    );

    // Winner's request fields, with the range decision made before registering.
    always_comb begin
        acc_sel = '0;
        if (pick_winner == PortA) begin
            acc_sel.we    = a_we;
            acc_sel.addr  = a_addr;
            acc_sel.wdata = a_wdata;
        end else begin
            acc_sel.we    = b_we;
            acc_sel.addr  = b_addr;
            acc_sel.wdata = b_wdata;
        end
        acc_sel.in_range = addr_in_range(acc_sel.addr, ADDR_LIMIT);
    end

    assign sample = (state_q == StIdle) && pick_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (pick_valid) state_d = StAccess;
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        a_err     = 1'b0;
        b_err     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state_q)
            StAccess: begin
                a_gnt     = (port_q == PortA);
                b_gnt     = (port_q == PortB);
                a_err     = (port_q == PortA) && !acc_q.in_range;
                b_err     = (port_q == PortB) && !acc_q.in_range;
                mem_read  = acc_q.in_range && (acc_q.we == CommandRead);
                mem_write = acc_q.in_range && (acc_q.we == CommandWrite);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= PortB;
            port_q       <= PortA;
            acc_q        <= '0;
        end else if (sample) begin
            last_grant_q <= pick_winner;
            port_q       <= pick_winner;
            acc_q        <= acc_sel;
        end
    end

    assign rd_done  = (state_q == StAccess) && (acc_q.we == CommandRead);
    assign cap_byte = acc_q.in_range ? mem_read_byte : 8'h00;

    // Only the winning port's read result moves; the other port's rdata holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 8'h00;
            b_rdata_q  <= 8'h00;
        end else begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            if (rd_done && port_q == PortA) begin
                a_rvalid_q <= 1'b1;
                a_rdata_q  <= cap_byte;
            end
            if (rd_done && port_q == PortB) begin
                b_rvalid_q <= 1'b1;
                b_rdata_q  <= cap_byte;
            end
        end
    end

    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign mem_addr       = acc_q.addr;
    assign mem_write_byte = acc_q.wdata;

    gnt_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt && b_gnt));
    strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester drivers feed a scoreboard; a monitor checks grants,
// strobes and read data against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned Limit = 32'h2000;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [7:0]  a_rdata, b_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_byte, mem_read_byte;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_byte(mem_write_byte), .mem_read_byte(mem_read_byte)
    );

    // Fixed-priority instance, exercised on its own at the end.
    logic        fp_a_req = 1'b0, fp_b_req = 1'b0;
    logic        fp_a_gnt, fp_a_rvalid, fp_a_err, fp_b_gnt, fp_b_rvalid, fp_b_err;
    logic [7:0]  fp_a_rdata, fp_b_rdata;
    logic        fp_mem_read, fp_mem_write;
    logic [15:0] fp_mem_addr;
    logic [7:0]  fp_mem_write_byte;

    mem_arbiter #(.ADDR_LIMIT(Limit), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(fp_a_req), .a_we(1'b0), .a_addr(16'h0020), .a_wdata(8'h00),
        .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata), .a_err(fp_a_err),
        .b_req(fp_b_req), .b_we(1'b0), .b_addr(16'h0030), .b_wdata(8'h00),
        .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata), .b_err(fp_b_err),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
        .mem_write_byte(fp_mem_write_byte), .mem_read_byte(8'h77)
    );

    // Byte memory seen by the main DUT.
    logic [7:0] mem [Limit];
    logic       mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(Limit); i++) mem[i] <= 8'h00;
        end else if (mem_write && {16'h0000, mem_addr} < Limit) begin
            mem[mem_addr[12:0]] <= mem_write_byte;
        end
    end
    assign mem_read_byte = (mem_read && {16'h0000, mem_addr} < Limit) ? mem[mem_addr[12:0]]
                                                                       : 8'hA5;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
    endtask

    // Reference model state.
    req_t       pend_a[$], pend_b[$];
    logic [7:0] rd_a_q[$], rd_b_q[$];
    logic [7:0] ref_mem [int];
    port_id_e   grant_log[$];
    bit         m_busy = 1'b0;
    port_id_e   m_last = PortB;
    bit         exp_valid = 1'b0;
    port_id_e   exp_port = PortA;
    bit         rst_at_edge = 1'b0;

    function automatic port_id_e arb_pick(input bit ar, input bit br, input port_id_e last);
        if (ar && br) return (last == PortA) ? PortB : PortA;
        return ar ? PortA : PortB;
    endfunction

    // Accepts at most one access per two cycles; expected grant is shown next cycle.
    always @(posedge clk) begin
        rst_at_edge <= !rst_n;
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_last    <= PortB;
            exp_valid <= 1'b0;
        end else if (!m_busy && (a_req || b_req)) begin
            exp_valid <= 1'b1;
            exp_port  <= arb_pick(a_req, b_req, m_last);
            m_last    <= arb_pick(a_req, b_req, m_last);
            m_busy    <= 1'b1;
        end else begin
            exp_valid <= 1'b0;
            m_busy    <= 1'b0;
        end
    end

    // Monitor: checks every cycle on the falling edge.
    initial begin
        bit         exp_rv_a = 1'b0, exp_rv_b = 1'b0, inr;
        logic [7:0] cur_a = 8'h00, cur_b = 8'h00, eb;
        req_t       r;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                check("reset_outputs", {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err,
                      mem_read, mem_write, mem_addr, mem_write_byte, a_rdata, b_rdata}, '0);
                pend_a.delete(); pend_b.delete(); rd_a_q.delete(); rd_b_q.delete();
                exp_rv_a = 1'b0; exp_rv_b = 1'b0; cur_a = 8'h00; cur_b = 8'h00;
            end else begin
                if (exp_rv_a) cur_a = rd_a_q.pop_front();
                if (exp_rv_b) cur_b = rd_b_q.pop_front();
                check("a_rvalid", a_rvalid, exp_rv_a);
                check("b_rvalid", b_rvalid, exp_rv_b);
                check("a_rdata", a_rdata, cur_a);
                check("b_rdata", b_rdata, cur_b);
                exp_rv_a = 1'b0;
                exp_rv_b = 1'b0;
                check("gnt", {a_gnt, b_gnt},
                      exp_valid ? ((exp_port == PortA) ? 2'b10 : 2'b01) : 2'b00);
                if (exp_valid) begin
                    if ((exp_port == PortA ? pend_a.size() : pend_b.size()) == 0) begin
                        fail_now("grant_without_request");
                    end else begin
                        r   = (exp_port == PortA) ? pend_a.pop_front() : pend_b.pop_front();
                        inr = {16'h0000, r.addr} < Limit;
                        check("mem_addr", mem_addr, r.addr);
                        check("strobes_err", {mem_read, mem_write, a_err, b_err},
                              {!r.we && inr, r.we && inr,
                               exp_port == PortA && !inr, exp_port == PortB && !inr});
                        if (r.we) check("mem_write_byte", mem_write_byte, r.wdata);
                        if (r.we && inr) begin
                            ref_mem[int'(r.addr)] = r.wdata;
                        end else if (!r.we) begin
                            eb = 8'h00;
                            if (inr && ref_mem.exists(int'(r.addr))) eb = ref_mem[int'(r.addr)];
                            if (exp_port == PortA) begin
                                rd_a_q.push_back(eb);
                                exp_rv_a = 1'b1;
                            end else begin
                                rd_b_q.push_back(eb);
                                exp_rv_b = 1'b1;
                            end
                        end
                        grant_log.push_back(exp_port);
                    end
                end else begin
                    check("idle_strobes", {mem_read, mem_write, a_err, b_err}, 4'b0000);
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge where the grant is seen.
    task automatic do_req(input port_id_e p, input logic we, input logic [15:0] addr,
                          input logic [7:0] wdata);
        req_t r;
        bit   got = 1'b0;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        if (p == PortA) begin
            pend_a.push_back(r);
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            pend_b.push_back(r);
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (p == PortA) ? a_gnt : b_gnt;
        end
        if (p == PortA) a_req = 1'b0;
        else b_req = 1'b0;
        if (!got) fail_now(p == PortA ? "a_gnt_timeout" : "b_gnt_timeout");
    endtask

    function automatic logic [15:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        if (k == 0) return 16'(32'h2000 + $urandom_range(0, 32'hDFFF));
        if (k == 1) return 16'h1FFF;
        return 16'(32'h0100 + $urandom_range(0, 7));
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        port_id_e   rr_exp[4];
        port_id_e   fp_exp[4];
        port_id_e   fp_log[$];
        int         na;
        bit         fp_done;
        rr_exp = '{PortA, PortB, PortA, PortB};
        fp_exp = '{PortA, PortA, PortA, PortB};

        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);

        // Round-robin contention straight after reset: A goes first.
        grant_log.delete();
        fork
            begin do_req(PortA, 1'b0, 16'h0040, 8'h00); do_req(PortA, 1'b0, 16'h0041, 8'h00); end
            begin do_req(PortB, 1'b0, 16'h0050, 8'h00); do_req(PortB, 1'b0, 16'h0051, 8'h00); end
        join
        repeat (2) @(negedge clk);
        check("rr_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr_order", grant_log[i], rr_exp[i]);

        // Single write then read back.
        do_req(PortA, 1'b1, 16'h0010, 8'h5A);
        check("a_write_strobe", {mem_write, mem_addr}, {1'b1, 16'h0010});
        @(negedge clk);
        check("a_write_one_cycle", mem_write, 1'b0);
        do_req(PortA, 1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        check("a_read_back", {a_rvalid, a_rdata}, {1'b1, 8'h5A});

        // Last in-range byte, then out-of-range write and read on port B.
        do_req(PortB, 1'b1, 16'h1FFF, 8'hC3);
        do_req(PortB, 1'b0, 16'h1FFF, 8'h00);
        @(negedge clk);
        check("b_read_top", {b_rvalid, b_rdata}, {1'b1, 8'hC3});
        do_req(PortB, 1'b1, 16'h2000, 8'h99);
        check("b_oor_write", {b_gnt, b_err, mem_write, mem_read}, 4'b1100);
        do_req(PortB, 1'b0, 16'hFFFF, 8'h00);
        check("b_oor_read", {b_gnt, b_err, mem_write, mem_read}, 4'b1100);
        @(negedge clk);
        check("b_oor_rdata", {b_rvalid, b_rdata}, {1'b1, 8'h00});
        check("a_rdata_untouched", a_rdata, 8'h5A);

        // Reset during the ACCESS cycle of an A read.
        do_req(PortA, 1'b0, 16'h1FFF, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_abort", {a_gnt, a_rvalid, mem_read, mem_write}, 4'b0000);
        rst_n = 1'b1;
        grant_log.delete();
        fork
            do_req(PortA, 1'b0, 16'h0010, 8'h00);
            do_req(PortB, 1'b0, 16'h1FFF, 8'h00);
        join
        repeat (2) @(negedge clk);
        check("post_reset_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("post_reset_first", grant_log[0], PortA);

        // Randomised traffic from both ports.
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_req(PortA, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_req(PortB, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            end
        join
        repeat (3) @(negedge clk);
        check("scoreboard_drained", pend_a.size() + pend_b.size() + rd_a_q.size() + rd_b_q.size(),
              0);

        // Fixed priority: A keeps requesting for three grants, B waits until A stops.
        @(negedge clk);
        fp_a_req = 1'b1;
        fp_b_req = 1'b1;
        na       = 0;
        fp_done  = 1'b0;
        for (int i = 0; i < 30 && !fp_done; i++) begin
            @(negedge clk);
            if (fp_a_gnt) begin
                fp_log.push_back(PortA);
                na++;
                if (na == 3) fp_a_req = 1'b0;
            end
            if (fp_b_gnt) begin
                fp_log.push_back(PortB);
                fp_b_req = 1'b0;
                fp_done  = 1'b1;
            end
        end
        fp_a_req = 1'b0;
        fp_b_req = 1'b0;
        check("fp_grant_count", fp_log.size(), 4);
        for (int i = 0; i < 4 && i < fp_log.size(); i++) check("fp_order", fp_log[i], fp_exp[i]);
        @(negedge clk);
        check("fp_rdata", {fp_b_rvalid, fp_b_rdata, fp_a_rdata}, {1'b1, 8'h77, 8'h77});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
